// File: rtl/efference_copy_generator.sv
// Efference-copy delay line: time-stamps motor commands, releases each one LAT sample ticks later scaled by a Q1.7 gain.
// Optional build macro EFF_GAIN_ADAPT_EN replaces the static gain input with a gain register adapted from comparator error.
module efference_copy_generator #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int LAT    = 4,
    parameter int GAIN_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [WIDTH-1:0]    motor_cmd,
    input  logic                       motor_valid,
    output logic                       motor_ready,
    input  logic                       sample_tick,
    input  logic [GAIN_W-1:0]          gain,
    output logic signed [WIDTH-1:0]    ref_glyph,
    output logic                       ref_valid,
    output logic                       ref_hit,
    output logic                       ref_sat,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
`ifdef EFF_GAIN_ADAPT_EN
    ,
    input  logic signed [WIDTH-1:0]    error_raw,
    input  logic                       error_valid
`endif
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PROD_W = WIDTH + GAIN_W + 1;
    localparam int SHIFT  = 7;

    localparam logic [CW-1:0]     CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]     CNT_FULL   = CW'(DEPTH);
    localparam logic [PW-1:0]     PTR_ONE    = PW'(1);
    localparam logic [7:0]        LAT_C      = 8'(LAT);
    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(128);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [WIDTH-1:0] cmd;
        logic [7:0]              stamp;
    } entry_t;

    typedef struct packed {
        logic                    sat;
        logic signed [WIDTH-1:0] val;
    } scale_t;

    // Signed cmd times unsigned gain, floor-shifted by the Q1.7 point, then clamped to the output range.
    function automatic scale_t scale_f(input logic signed [WIDTH-1:0] cmd,
                                       input logic [GAIN_W-1:0] g);
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shr;
        logic signed [PROD_W-1:0] max_v;
        logic signed [PROD_W-1:0] min_v;
        scale_t                   res;
        max_v = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
        min_v = {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
        prod  = $signed({{(GAIN_W+1){cmd[WIDTH-1]}}, cmd}) *
                $signed({{WIDTH{1'b0}}, 1'b0, g});
        shr   = prod >>> SHIFT;
        if (shr > max_v) begin
            res.sat = 1'b1;
            res.val = max_v[WIDTH-1:0];
        end else if (shr < min_v) begin
            res.sat = 1'b1;
            res.val = min_v[WIDTH-1:0];
        end else begin
            res.sat = 1'b0;
            res.val = shr[WIDTH-1:0];
        end
        return res;
    endfunction

    entry_t                  mem_r [DEPTH];
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [CW-1:0]           count_r;
    logic [7:0]              tick_cnt_r;
    state_t                  state_r;
    logic signed [WIDTH-1:0] ref_glyph_r;
    logic                    ref_valid_r;
    logic                    ref_hit_r;
    logic                    ref_sat_r;

    logic                    push_s;
    logic                    pop_s;
    entry_t                  head_s;
    scale_t                  scaled_s;
    logic [GAIN_W-1:0]       gain_eff_s;
    logic [7:0]              tick_nxt_s;
    logic [CW-1:0]           count_nxt_s;
    logic [7:0]              nxt_stamp_s;
    logic [7:0]              nxt_age_s;
    state_t                  state_nxt_s;

    assign motor_ready = (count_r != CNT_FULL);
    assign fill_level  = count_r;
    assign ref_glyph   = ref_glyph_r;
    assign ref_valid   = ref_valid_r;
    assign ref_hit     = ref_hit_r;
    assign ref_sat     = ref_sat_r;

    assign head_s   = mem_r[rd_ptr_r];
    assign scaled_s = scale_f(head_s.cmd, gain_eff_s);

    // Handshake decode and look-ahead classification of the head entry for the next cycle.
    always_comb begin
        push_s      = motor_valid && motor_ready;
        pop_s       = sample_tick && (state_r == ST_READY);
        tick_nxt_s  = sample_tick ? (tick_cnt_r + 8'd1) : tick_cnt_r;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        // After a pop the new head is either the next stored entry or the one being pushed right now.
        nxt_stamp_s = head_s.stamp;
        if (pop_s) begin
            if (count_r == CNT_ONE) begin
                nxt_stamp_s = tick_cnt_r;
            end else begin
                nxt_stamp_s = mem_r[rd_ptr_r + PTR_ONE].stamp;
            end
        end else if (count_r == CNT_ZERO) begin
            nxt_stamp_s = tick_cnt_r;
        end else begin
            nxt_stamp_s = head_s.stamp;
        end
        nxt_age_s = tick_nxt_s - nxt_stamp_s;
        if (count_nxt_s == CNT_ZERO) begin
            state_nxt_s = ST_EMPTY;
        end else if (nxt_age_s >= LAT_C) begin
            state_nxt_s = ST_READY;
        end else begin
            state_nxt_s = ST_WAIT;
        end
    end

    // Command storage: each entry carries the tick count at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(WIDTH+8){1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {motor_cmd, tick_cnt_r};
        end
    end

    // Control FSM: tick counter, FIFO pointers/occupancy and the registered reafference outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            tick_cnt_r  <= 8'd0;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= CNT_ZERO;
            ref_glyph_r <= {WIDTH{1'b0}};
            ref_valid_r <= 1'b0;
            ref_hit_r   <= 1'b0;
            ref_sat_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_nxt_s;
            count_r    <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (sample_tick) begin
                ref_valid_r <= 1'b1;
                if (pop_s) begin
                    ref_glyph_r <= scaled_s.val;
                    ref_hit_r   <= 1'b1;
                    ref_sat_r   <= scaled_s.sat;
                end else begin
                    // No efference in flight means no expected reafference.
                    ref_glyph_r <= {WIDTH{1'b0}};
                    ref_hit_r   <= 1'b0;
                    ref_sat_r   <= 1'b0;
                end
            end else begin
                ref_valid_r <= 1'b0;
            end
        end
    end

`ifdef EFF_GAIN_ADAPT_EN
    logic [GAIN_W-1:0] gain_r;
    logic              adapt_pend_r;

    assign gain_eff_s = gain_r;

    // Sign-agreement gain adaptation, judged on the cycle after a released prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_r       <= GAIN_UNITY;
            adapt_pend_r <= 1'b0;
        end else begin
            adapt_pend_r <= ref_valid_r && ref_hit_r;
            if (adapt_pend_r && error_valid &&
                (error_raw != {WIDTH{1'b0}}) && (ref_glyph_r != {WIDTH{1'b0}})) begin
                if (error_raw[WIDTH-1] != ref_glyph_r[WIDTH-1]) begin
                    if (gain_r != {GAIN_W{1'b0}}) begin
                        gain_r <= gain_r - GAIN_W'(1);
                    end
                end else begin
                    if (gain_r != {GAIN_W{1'b1}}) begin
                        gain_r <= gain_r + GAIN_W'(1);
                    end
                end
            end
        end
    end
`else
    assign gain_eff_s = gain;
`endif

endmodule

// File: tb/tb_efference_copy_generator.sv
// Directed scoreboard bench for efference_copy_generator (default build, LAT=4, DEPTH=8).
module tb_efference_copy_generator;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] motor_cmd = 16'sd0;
    logic               motor_valid = 1'b0;
    logic               motor_ready;
    logic               sample_tick = 1'b0;
    logic [7:0]         gain = 8'd128;
    logic signed [15:0] ref_glyph;
    logic               ref_valid;
    logic               ref_hit;
    logic               ref_sat;
    logic [3:0]         fill_level;
`ifdef EFF_GAIN_ADAPT_EN
    logic signed [15:0] error_raw = 16'sd0;
    logic               error_valid = 1'b0;
`endif

    typedef struct {
        int glyph;
        int hit;
        int sat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    efference_copy_generator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .motor_cmd   (motor_cmd),
        .motor_valid (motor_valid),
        .motor_ready (motor_ready),
        .sample_tick (sample_tick),
        .gain        (gain),
        .ref_glyph   (ref_glyph),
        .ref_valid   (ref_valid),
        .ref_hit     (ref_hit),
        .ref_sat     (ref_sat),
        .fill_level  (fill_level)
`ifdef EFF_GAIN_ADAPT_EN
        ,
        .error_raw   (error_raw),
        .error_valid (error_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // One clock of stimulus: inputs applied just after a rising edge, sampled at the next one.
    task automatic step(input logic mv, input int mc, input logic tk);
        motor_valid = mv;
        motor_cmd   = 16'(mc);
        sample_tick = tk;
        @(posedge clk);
        #1;
        motor_valid = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic tick_exp(input int g, input int h, input int s);
        exp_t e;
        e.glyph = g; e.hit = h; e.sat = s;
        sb_q.push_back(e);
        step(1'b0, 0, 1'b1);
    endtask

    task automatic push(input int c);
        step(1'b1, c, 1'b0);
    endtask

    task automatic misses(input int n);
        for (int i = 0; i < n; i++) tick_exp(0, 0, 0);
    endtask

    // Monitor: every ref_valid pulse is matched against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ref_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: ref_valid with glyph %0d, expected no pulse", ref_glyph);
                end else begin
                    e = sb_q.pop_front();
                    chk("ref_glyph", int'(ref_glyph), e.glyph);
                    chk("ref_hit", int'(ref_hit), e.hit);
                    chk("ref_sat", int'(ref_sat), e.sat);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #3;
        chk("rst_glyph", int'(ref_glyph), 0);
        chk("rst_valid", int'(ref_valid), 0);
        chk("rst_hit", int'(ref_hit), 0);
        chk("rst_sat", int'(ref_sat), 0);
        chk("rst_fill", int'(fill_level), 0);
        chk("rst_ready", int'(motor_ready), 1);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Push 100 together with the tick at tick_cnt 0; it pops on the tick seen at tick_cnt 4.
        sb_q.push_back('{0, 0, 0});
        step(1'b1, 100, 1'b1);
        chk("fill_one", int'(fill_level), 1);
        misses(3);
        tick_exp(100, 1, 0);
        chk("fill_drained", int'(fill_level), 0);

        // tick_cnt 5: gain 0.5 on -7 floors to -4.
        gain = 8'd64;
        push(-7);
        misses(4);
        tick_exp(-4, 1, 0);

        // tick_cnt 10: gain 255 saturates both directions.
        gain = 8'd255;
        push(30000);
        push(-30000);
        misses(4);
        tick_exp(32767, 1, 1);
        tick_exp(-32768, 1, 1);

        // tick_cnt 16: fill the FIFO, ninth push is refused.
        gain = 8'd128;
        for (int i = 1; i <= 9; i++) begin
            push(i * 10);
            if (i == 8) begin
                chk("full_fill", int'(fill_level), 8);
                chk("full_ready", int'(motor_ready), 0);
            end
        end
        chk("full_fill_after9", int'(fill_level), 8);
        misses(4);
        tick_exp(10, 1, 0);
        chk("drain_fill", int'(fill_level), 7);
        chk("drain_ready", int'(motor_ready), 1);
        // Push 500 on the same tick that pops 20: occupancy stays at 7.
        sb_q.push_back('{20, 1, 0});
        step(1'b1, 500, 1'b1);
        chk("pushpop_fill", int'(fill_level), 7);
        for (int i = 3; i <= 8; i++) tick_exp(i * 10, 1, 0);
        tick_exp(500, 1, 0);
        chk("empty_fill", int'(fill_level), 0);
        step(1'b0, 0, 1'b0);

        // Reset with three entries queued and 500 held on ref_glyph.
        push(11);
        push(22);
        push(33);
        chk("pre_rst_fill", int'(fill_level), 3);
        chk("pre_rst_glyph", int'(ref_glyph), 500);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_fill", int'(fill_level), 0);
        chk("mid_rst_glyph", int'(ref_glyph), 0);
        chk("mid_rst_hit", int'(ref_hit), 0);
        chk("mid_rst_ready", int'(motor_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick_exp(0, 0, 0);
        // tick_cnt restarted: push at 1 pops on the tick seen at 5.
        push(77);
        misses(4);
        tick_exp(77, 1, 0);

        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/efference_copy_generator.md
# efference_copy_generator

Produces the expected-reafference word `ref_glyph` that `reafference_comparator` subtracts from `scrape`. Accepts motor efference-copy commands over a valid/ready interface and time-stamps each one. Each command is held until the sensor loop has advanced by the sensorimotor latency, then scaled by a gain and presented as `ref_glyph`, aligned to the sensor sampling strobe.

## Interface
- `WIDTH`, 16: motor command and `ref_glyph` width, signed two's complement.
- `DEPTH`, 8: command FIFO entries; power of two, ≥2.
- `LAT`, 4: latency in `sample_tick` events from acceptance to release; 1..127; `LAT+DEPTH` ≤ 255.
- `GAIN_W`, 8: gain width; unsigned Q1.7, so 128 = 1.0.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `motor_cmd`  in  WIDTH  signed efference copy.
- `motor_valid`  in  1  `motor_cmd` offered.
- `motor_ready`  out  1  FIFO not full.
- `sample_tick`  in  1  one-cycle sensor sampling strobe.
- `gain`  in  GAIN_W  static gain; ignored when adaptation is compiled in.
- `ref_glyph`  out  WIDTH  expected reafference; held between updates.
- `ref_valid`  out  1  one-cycle pulse; `ref_glyph` updated.
- `ref_hit`  out  1  qualifies `ref_valid`: 1 = released command, 0 = no prediction.
- `ref_sat`  out  1  qualifies `ref_valid`: the scaled value was saturated.
- `fill_level`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `error_raw`  in  WIDTH  comparator error; present only with `EFF_GAIN_ADAPT_EN`.
- `error_valid`  in  1  comparator valid; present only with `EFF_GAIN_ADAPT_EN`.

## Operation
- **Tick counter:** 8-bit `tick_cnt`, reset 0, increments (wrapping) on each `sample_tick`.
- **Push:**
  - A command is accepted when `motor_valid && motor_ready`.
  - The FIFO stores `{motor_cmd, stamp = current tick_cnt}`.
  - `motor_ready = (fill_level != DEPTH)`, combinational from registered count.
- **Release, on each `sample_tick`:**
  - Compute `age = tick_cnt - head.stamp` mod 256.
  - If the FIFO is non-empty and `age >= LAT`: pop the head. Set `ref_glyph <= scale(head.cmd)`, `ref_hit <= 1`, `ref_sat <=` saturation flag.
  - Otherwise: set `ref_glyph <= 0`, `ref_hit <= 0`, `ref_sat <= 0`. No efference means no expected reafference.
  - `ref_valid <= 1` in both cases. At most one pop per tick; backlog drains one entry per tick.
- **Scale:**
  - Multiply signed `cmd` × zero-extended `gain` into a WIDTH+GAIN_W+1 signed product.
  - Arithmetic shift right by 7, so the result floors.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- **State (2-bit, registered):**
  - EMPTY (count 0).
  - WAIT (non-empty, head age < LAT).
  - READY (head age ≥ LAT).
  - Transitions are re-evaluated every cycle from count and head age. READY → WAIT/EMPTY on pop.
- **Simultaneous push and pop:** both occur; count unchanged. A command pushed on a tick cycle takes the pre-increment stamp.
- **Reset mid-operation:** FIFO flushed, `tick_cnt` 0, all outputs to reset values immediately (asynchronous assertion).
- **Reset values:**
  - `ref_glyph` 0, `ref_valid` 0, `ref_hit` 0, `ref_sat` 0, `fill_level` 0.
  - `motor_ready` 1, since it is combinational from an empty FIFO.

## Timing
- `ref_*` are registered and update on the edge that samples `sample_tick`.
- Latency: a command accepted while `tick_cnt = t` appears in `ref_glyph` on the edge of the tick seen with `tick_cnt = t+LAT`, provided it is at the head.
- `ref_valid` is high for exactly one cycle per `sample_tick`.
- `ref_glyph` holds its value until the next tick.
- `fill_level` is registered and reflects push/pop one cycle later.

## Configuration
- `EFF_GAIN_ADAPT_EN` defined:
  - Adds `error_raw` and `error_valid`.
  - The effective gain is an internal GAIN_W register, reset 128; the `gain` input is ignored.
  - Update condition: one cycle after `ref_valid && ref_hit`, if `error_valid` is high.
  - Decrement if `sign(error_raw) != sign(ref_glyph)`; increment if the signs are equal. No change if `error_raw == 0` or `ref_glyph == 0`.
  - Clamped to 0..2^GAIN_W-1.
- Undefined: effective gain = `gain` input; no adaptation logic and no error ports.

## Test plan
- Defaults (LAT=4, gain=128): push 100 at `tick_cnt` 0, then 4 ticks → `ref_glyph` = 100 with `ref_valid` and `ref_hit` = 1 on the 4th tick; ticks 1–3 give `ref_glyph` 0 with `ref_hit` 0.
- Gain 64, cmd -7 → `ref_glyph` = -4 (floor), `ref_sat` = 0.
- Gain 255, cmd 30000 → `ref_glyph` = 32767, `ref_sat` = 1.
- Push 9 commands with no ticks → 8 accepted, `motor_ready` = 0, `fill_level` = 8. After LAT ticks, one pop per tick and `motor_ready` returns to 1.
- Reset asserted with 3 entries queued → `fill_level` 0 and `ref_glyph` 0 immediately. After reset, a tick gives `ref_hit` 0.
- With `EFF_GAIN_ADAPT_EN`: hit with `ref_glyph` 100, then `error_raw` = +5 → gain 128→129. Next hit with `error_raw` = -3 → gain 128. Gain 0 with a decrement stays 0.
